// File: rtl/cntr_seq_ctrl.sv
// cntr_seq_ctrl: sequencer for the n-bit load/count-up/hold counter.
// Loads a preset into the counter, lets it advance on each prescaler tick,
// and finishes the interval when a tick arrives while the counter reads all
// ones. Pause, resume, abort and auto-repeat are supported. A one-cycle done
// pulse marks each completed interval, and iter counts completed intervals.
//
// There is no valid/ready traffic here. start, stop and tick are plain
// levels sampled on every rising clk edge. tick is a one-cycle strobe from
// the prescaler; a tick that arrives outside RUN is dropped.
module cntr_seq_ctrl #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic         tick,
    input  logic         mode_rpt,
    input  logic [n-1:0] preset,
    input  logic [n-1:0] cnt_q,
    output logic         cnt_ld,
    output logic         cnt_up,
    output logic [n-1:0] cnt_d,
    output logic         busy,
    output logic         done,
    output logic [7:0]   iter
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]   state;
    logic [2:0]   state_nx;
    logic [n-1:0] preset_r;
    logic         rpt_r;
    logic         term;

    // The counter has reached its terminal value (all ones).
    assign term = &cnt_q;

    // Next-state selection. In RUN, a terminal tick wins over a concurrent
    // stop. In PAUSE, stop (abort) wins over start (resume).
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_RUN;
            S_RUN: begin
                if (tick && term) state_nx = S_DONE;
                else if (stop)    state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (stop)       state_nx = S_IDLE;
                else if (start) state_nx = S_RUN;
            end
            S_DONE:  state_nx = rpt_r ? S_LOAD : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Capture the interval setup when a start is accepted in IDLE.
    // The captured preset also feeds the counter load data.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            preset_r <= '0;
            rpt_r    <= 1'b0;
        end else if (state == S_IDLE && start) begin
            preset_r <= preset;
            rpt_r    <= mode_rpt;
        end
    end

    // Completed-interval tally. It clears when a new sequence starts from
    // IDLE and wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                           iter <= 8'd0;
        else if (state == S_IDLE && start) iter <= 8'd0;
        else if (state == S_DONE)          iter <= iter + 8'd1;
    end

    // Output decode. cnt_up is gated by term so the counter never wraps past
    // all ones. A stop that arrives with a non-terminal tick still lets that
    // tick count.
    always_comb begin
        cnt_ld = (state == S_LOAD);
        cnt_up = (state == S_RUN) && tick && !term;
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        cnt_d  = preset_r;
    end

endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Bench for cntr_seq_ctrl with a 4-bit counter. The bench includes a
// behavioural load/up/hold counter that closes the loop through cnt_q. An
// interval-level reference model predicts every output on every cycle.
module tb_cntr_seq_ctrl;

  localparam int N = 4;
  localparam int TOP = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         stop;
  logic         tick;
  logic         mode_rpt;
  logic [N-1:0] preset;
  logic [N-1:0] cnt_q;
  logic         cnt_ld;
  logic         cnt_up;
  logic [N-1:0] cnt_d;
  logic         busy;
  logic         done;
  logic [7:0]   iter;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic seen_done;

  cntr_seq_ctrl #(.n(N)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .tick(tick),
    .mode_rpt(mode_rpt), .preset(preset), .cnt_q(cnt_q),
    .cnt_ld(cnt_ld), .cnt_up(cnt_up), .cnt_d(cnt_d),
    .busy(busy), .done(done), .iter(iter)
  );

  // clock / reset
  always #5 clk = ~clk;

  // controlled counter: load has priority, otherwise up, otherwise hold
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         cnt_q <= '0;
    else if (cnt_ld) cnt_q <= cnt_d;
    else if (cnt_up) cnt_q <= cnt_q + 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: the interval phase, the captured setup, the tally
  // and the value the counter should be holding
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_PAUSE = 3, P_DONE = 4;
  int m_ph, m_pre, m_rpt, m_iter, m_cnt;

  task automatic model_reset();
    m_ph = P_IDLE; m_pre = 0; m_rpt = 0; m_iter = 0; m_cnt = 0;
  endtask

  task automatic model_check();
    int e_up;
    e_up = (m_ph == P_RUN && tick && m_cnt != TOP) ? 1 : 0;
    check("busy",   32'(busy),   32'(m_ph != P_IDLE));
    check("cnt_ld", 32'(cnt_ld), 32'(m_ph == P_LOAD));
    check("cnt_up", 32'(cnt_up), 32'(e_up));
    check("done",   32'(done),   32'(m_ph == P_DONE));
    check("cnt_d",  32'(cnt_d),  32'(m_pre));
    check("iter",   32'(iter),   32'(m_iter));
    check("cnt_q",  32'(cnt_q),  32'(m_cnt));
  endtask

  task automatic model_advance();
    bit last;
    last = (m_cnt == TOP);
    if (m_ph == P_LOAD) m_cnt = m_pre;
    else if (m_ph == P_RUN && tick && !last) m_cnt = m_cnt + 1;
    case (m_ph)
      P_IDLE: if (start) begin
        m_ph = P_LOAD; m_pre = int'(preset); m_rpt = int'(mode_rpt); m_iter = 0;
      end
      P_LOAD:  m_ph = P_RUN;
      P_RUN: begin
        if (tick && last) m_ph = P_DONE;
        else if (stop)    m_ph = P_PAUSE;
      end
      P_PAUSE: begin
        if (stop)       m_ph = P_IDLE;
        else if (start) m_ph = P_RUN;
      end
      default: begin
        m_iter = (m_iter + 1) % 256;
        m_ph = m_rpt ? P_LOAD : P_IDLE;
      end
    endcase
  endtask

  // driver tasks
  task automatic drive(input logic s, input logic p, input logic t, input logic r,
                       input logic [N-1:0] pr);
    start = s; stop = p; tick = t; mode_rpt = r; preset = pr;
  endtask

  // one clock: check on the falling edge, advance the model at the rising
  // edge, and return just after it
  task automatic cycle();
    @(negedge clk);
    model_check();
    seen_done = done;
    @(posedge clk);
    model_advance();
    cyc++;
    #1;
  endtask

  // asynchronous clear in the middle of a cycle
  task automatic async_clr();
    #1 clr = 1'b1;
    #1;
    check("clr_busy",   32'(busy),   32'd0);
    check("clr_done",   32'(done),   32'd0);
    check("clr_cnt_ld", 32'(cnt_ld), 32'd0);
    check("clr_cnt_up", 32'(cnt_up), 32'd0);
    check("clr_iter",   32'(iter),   32'd0);
    check("clr_cnt_q",  32'(cnt_q),  32'd0);
    model_reset();
    #1 clr = 1'b0;
  endtask

  typedef struct {
    logic s, p, t, r;
    logic [N-1:0] pr;
    logic busy, ld, up, done;
    logic [N-1:0] cnt;
    logic [N-1:0] d;
    logic [7:0] it;
  } vec_t;

  vec_t vt[11];
  int q_done[$];

  initial begin
    // single shot with preset C: pause with a concurrent tick, a stray tick
    // in PAUSE, then a stop that coincides with the terminal tick
    //            s  p  t  r  pr    busy ld up dn cnt  d    it
    vt[0]  = '{1, 0, 0, 0, 4'hC, 0, 0, 0, 0, 4'h0, 4'h0, 0};
    vt[1]  = '{0, 0, 0, 0, 4'h0, 1, 1, 0, 0, 4'h0, 4'hC, 0};
    vt[2]  = '{0, 0, 1, 0, 4'h0, 1, 0, 1, 0, 4'hC, 4'hC, 0};
    vt[3]  = '{0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 4'hD, 4'hC, 0};
    vt[4]  = '{0, 0, 1, 0, 4'h0, 1, 0, 1, 0, 4'hD, 4'hC, 0};
    vt[5]  = '{0, 1, 1, 0, 4'h0, 1, 0, 1, 0, 4'hE, 4'hC, 0};
    vt[6]  = '{0, 0, 1, 0, 4'h0, 1, 0, 0, 0, 4'hF, 4'hC, 0};
    vt[7]  = '{1, 0, 0, 0, 4'h0, 1, 0, 0, 0, 4'hF, 4'hC, 0};
    vt[8]  = '{0, 1, 1, 0, 4'h0, 1, 0, 0, 0, 4'hF, 4'hC, 0};
    vt[9]  = '{1, 1, 0, 0, 4'h0, 1, 0, 0, 1, 4'hF, 4'hC, 0};
    vt[10] = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 4'hF, 4'hC, 1};

    clr = 1'b1;
    drive(0, 0, 0, 0, '0);
    model_reset();
    #12;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_cnt_ld", 32'(cnt_ld), 32'd0);
    check("rst_cnt_d",  32'(cnt_d),  32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_iter",   32'(iter),   32'd0);
    clr = 1'b0;
    @(posedge clk); #1;

    // table-driven vectors
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].s, vt[i].p, vt[i].t, vt[i].r, vt[i].pr);
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), 32'(busy),   32'(vt[i].busy));
      check($sformatf("vec%0d_ld", i),   32'(cnt_ld), 32'(vt[i].ld));
      check($sformatf("vec%0d_up", i),   32'(cnt_up), 32'(vt[i].up));
      check($sformatf("vec%0d_done", i), 32'(done),   32'(vt[i].done));
      check($sformatf("vec%0d_cnt", i),  32'(cnt_q),  32'(vt[i].cnt));
      check($sformatf("vec%0d_d", i),    32'(cnt_d),  32'(vt[i].d));
      check($sformatf("vec%0d_iter", i), 32'(iter),   32'(vt[i].it));
      model_check();
      @(posedge clk);
      model_advance();
      #1;
    end

    // edge presets: an all-ones preset needs 1 tick; a preset of 0 needs 2^n
    for (int k = 0; k < 2; k++) begin
      int ticks;
      bit got;
      logic [N-1:0] pv;
      pv = (k == 0) ? 4'hF : 4'h0;
      drive(1, 0, 0, 0, pv); cycle();
      drive(0, 0, 0, 0, '0); cycle();
      ticks = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        tick = 1'b1;
        cycle();
        if (seen_done) got = 1;
        else ticks++;
      end
      check("edge_done_seen", 32'(got), 32'd1);
      check("edge_ticks", 32'(ticks), (k == 0) ? 32'd1 : 32'd16);
      check("edge_hold_f", 32'(cnt_q), 32'hF);
      tick = 1'b0;
      cycle();
      check("edge_idle", 32'(busy), 32'd0);
    end

    // pause at 5, ignored ticks, resume, then abort with stop, stop
    drive(1, 0, 0, 0, 4'h3); cycle();
    drive(0, 0, 0, 0, '0); cycle();
    tick = 1; cycle(); cycle();
    drive(0, 1, 0, 0, '0); cycle();
    drive(0, 0, 1, 0, '0); cycle(); cycle(); cycle();
    check("pause_hold", 32'(cnt_q), 32'd5);
    drive(1, 0, 0, 0, '0); cycle();
    drive(0, 0, 1, 0, '0); cycle();
    check("resume_step", 32'(cnt_q), 32'd6);
    drive(0, 1, 0, 0, '0); cycle(); cycle();
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_iter", 32'(iter), 32'd0);
    drive(0, 0, 0, 0, '0); cycle();

    // repeat mode with continuous ticks: 2 ticks + DONE + LOAD per interval
    q_done.delete();
    drive(1, 0, 1, 1, 4'hE); cycle();
    drive(0, 0, 1, 0, '0);
    for (int i = 0; i < 40 && q_done.size() < 3; i++) begin
      cycle();
      if (seen_done) begin
        q_done.push_back(cyc);
        check("rpt_reload", 32'(cnt_ld), 32'd1);
      end
    end
    check("rpt_count", 32'(q_done.size()), 32'd3);
    if (q_done.size() == 3) begin
      check("rpt_gap1", 32'(q_done[1] - q_done[0]), 32'd4);
      check("rpt_gap2", 32'(q_done[2] - q_done[1]), 32'd4);
    end
    check("rpt_iter", 32'(iter), 32'd3);
    stop = 1'b1;
    for (int i = 0; i < 10 && busy; i++) cycle();
    check("rpt_end", 32'(busy), 32'd0);
    check("rpt_iter_kept", 32'(iter), 32'd3);
    drive(0, 0, 0, 0, '0); cycle();

    // asynchronous clear in mid-RUN, then a normal start
    drive(1, 0, 0, 0, 4'h2); cycle();
    drive(0, 0, 1, 0, '0); cycle(); cycle(); cycle();
    async_clr();
    tick = 1'b0;
    drive(1, 0, 0, 0, 4'h9); cycle();
    drive(0, 0, 0, 0, '0); cycle();
    check("post_clr_load", 32'(cnt_q), 32'h9);

    // randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            N'($urandom_range(0, TOP)));
      cycle();
      if ($urandom_range(0, 499) == 0) async_clr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
